// File: rtl/display_pkg.sv
// Shared glyph table, frame FSM states and digit-step helpers for the serial BCD display.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } frame_state_e;

  // Segment order is {g,f,e,d,c,b,a}; codes 10-15 never occur and stay dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/dabble_digit.sv
// One BCD digit of the serial double-dabble converter: add-3 correction, shift, carry out.
module dabble_digit
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] digit_q;
  logic [3:0] base;
  logic [3:0] adj;

  // A clear coinciding with a shift acts on a zeroed digit, so the new frame's
  // first bit lands cleanly.
  always_comb begin
    base = clr ? 4'd0 : digit_q;
    adj  = dabble_adj(base);
  end

  assign cout = adj[3];
  assign q    = digit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else if (en) begin
      digit_q <= {adj[2:0], cin};
    end else if (clr) begin
      digit_q <= 4'd0;
    end
  end

endmodule

// File: rtl/serial_bcd_display.sv
// Serial MSB-first binary to multi-digit BCD converter driving 7-segment outputs,
// with framing, overflow detection, leading-zero blanking and selectable polarity.
module serial_bcd_display
  import display_pkg::*;
#(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned BITS       = 8,
  parameter bit          BLANK_LZ   = 1'b0,
  parameter bit          OVF_DASH   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  frame_start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  done,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned    CW     = $clog2(BITS + 1);
  localparam logic [CW-1:0]  CNT_1  = CW'(1);
  localparam logic [CW-1:0]  BITS_C = CW'(BITS);

  frame_state_e          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sticky_q, sticky_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic                  restart;
  logic                  accept;
  logic                  last;
  logic [CW-1:0]         cnt_next;
  logic                  sticky_next;
  logic [DIGITS:0]       carry;
  logic [3:0]            acc [DIGITS];
  logic [4*DIGITS-1:0]   post;

  assign restart = din_valid & frame_start;
  assign accept  = din_valid & (frame_start | (state_q == StShift));

  assign carry[0] = din;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] adj;

    dabble_digit u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (restart),
      .en   (accept),
      .cin  (carry[i]),
      .q    (acc[i]),
      .cout (carry[i+1])
    );

    // Post-shift view of this digit so the final bit's edge can latch the result.
    assign adj             = dabble_adj(restart ? 4'd0 : acc[i]);
    assign post[4*i +: 4]  = {adj[2:0], carry[i]};
  end

  assign cnt_next    = (restart ? '0 : cnt_q) + CNT_1;
  assign sticky_next = (restart ? 1'b0 : sticky_q) | carry[DIGITS];
  assign last        = accept && (cnt_next == BITS_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (accept) begin
      cnt_d    = cnt_next;
      sticky_d = sticky_next;
      state_d  = StShift;
      if (last) begin
        state_d = StIdle;
        cnt_d   = '0;
        bcd_d   = post;
        ovf_d   = sticky_next;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign done = done_q;
  assign busy = (state_q == StShift);

  // Walk from the top digit down so "any nonzero digit above" is known per digit.
  always_comb begin
    logic [6:0] glyph;
    logic       nz_above;
    seg      = '0;
    nz_above = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      glyph = bcd_to_seg(bcd_q[4*i +: 4]);
      if (OVF_DASH && ovf_q) begin
        glyph = SEG_DASH;
      end else if (BLANK_LZ && (i != 0) && !nz_above && (bcd_q[4*i +: 4] == 4'd0)) begin
        glyph = SEG_BLANK;
      end
      nz_above          = nz_above | (bcd_q[4*i +: 4] != 4'd0);
      seg[7*i +: 7]     = glyph ^ {7{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_serial_bcd_display.sv
// Scoreboard bench: four configurations of serial_bcd_display share din/frame_start,
// din_valid is steered to one selected instance; expected frames are checked on done.
module tb_serial_bcd_display;

  typedef struct {
    int unsigned  inst;
    logic [15:0]  bcd;
    logic         ovf;
    logic [27:0]  seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic frame_start = 1'b0;
  int   sel = 0;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Per-instance configuration: A, B, C (blank), D (4 digits, active low).
  int unsigned cfg_digits [4] = '{3, 3, 3, 4};
  int unsigned cfg_bits   [4] = '{8, 10, 8, 14};
  bit          cfg_blank  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit          cfg_al     [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0]  glyph_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                  7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  logic [11:0] bcd_a, bcd_b, bcd_c;
  logic [15:0] bcd_d;
  logic [20:0] seg_a, seg_b, seg_c;
  logic [27:0] seg_d;
  logic [3:0]  done_v, ovf_v, busy_v, dv;
  logic [15:0] bcd_all [4];
  logic [27:0] seg_all [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dv
    assign dv[k] = din_valid && (sel == k);
  end

  serial_bcd_display #(.DIGITS(3), .BITS(8), .BLANK_LZ(1'b0), .OVF_DASH(1'b1),
                       .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv[0]), .frame_start(frame_start),
    .bcd(bcd_a), .seg(seg_a), .done(done_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));

  serial_bcd_display #(.DIGITS(3), .BITS(10), .BLANK_LZ(1'b0), .OVF_DASH(1'b1),
                       .ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv[1]), .frame_start(frame_start),
    .bcd(bcd_b), .seg(seg_b), .done(done_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));

  serial_bcd_display #(.DIGITS(3), .BITS(8), .BLANK_LZ(1'b1), .OVF_DASH(1'b1),
                       .ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv[2]), .frame_start(frame_start),
    .bcd(bcd_c), .seg(seg_c), .done(done_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));

  serial_bcd_display #(.DIGITS(4), .BITS(14), .BLANK_LZ(1'b0), .OVF_DASH(1'b1),
                       .ACTIVE_LOW(1'b1)) u_d (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv[3]), .frame_start(frame_start),
    .bcd(bcd_d), .seg(seg_d), .done(done_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]));

  assign bcd_all[0] = {4'b0, bcd_a};
  assign bcd_all[1] = {4'b0, bcd_b};
  assign bcd_all[2] = {4'b0, bcd_c};
  assign bcd_all[3] = bcd_d;
  assign seg_all[0] = {7'b0, seg_a};
  assign seg_all[1] = {7'b0, seg_b};
  assign seg_all[2] = {7'b0, seg_c};
  assign seg_all[3] = seg_d;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p = 1;
    for (int i = 0; i < int'(n); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] model_bcd(input int unsigned v, input int unsigned digits);
    logic [15:0] r = '0;
    int unsigned x = v;
    for (int i = 0; i < int'(digits); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned v, input int unsigned digits);
    return v >= pow10(digits);
  endfunction

  function automatic logic [27:0] model_seg(input int unsigned v, input int unsigned k);
    logic [27:0] s = '0;
    logic [6:0]  g;
    int unsigned d [8];
    int unsigned x = v;
    int          hi = 0;
    for (int i = 0; i < int'(cfg_digits[k]); i++) begin
      d[i] = x % 10;
      x = x / 10;
      if (d[i] != 0) hi = i;
    end
    for (int i = 0; i < int'(cfg_digits[k]); i++) begin
      if (model_ovf(v, cfg_digits[k])) g = 7'b1000000;
      else if (cfg_blank[k] && i > hi) g = 7'b0000000;
      else g = glyph_tab[d[i]];
      if (cfg_al[k]) g = ~g;
      s[7*i +: 7] = g;
    end
    return s;
  endfunction

  // Each done pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 64'(k + 100), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check_eq("done_inst", 64'(k), 64'(mon_e.inst));
          check_eq("bcd", 64'(bcd_all[k]), 64'(mon_e.bcd));
          check_eq("ovf", 64'(ovf_v[k]), 64'(mon_e.ovf));
          check_eq("seg", 64'(seg_all[k]), 64'(mon_e.seg));
        end
      end
    end
  end

  task automatic drive_bits(input int unsigned v, input int nbits, input int max_gap,
                            input bit fs_first, input bit exp_done, input bit exp_busy);
    exp_t e;
    if (exp_done) begin
      e.inst = sel;
      e.bcd  = model_bcd(v, cfg_digits[sel]);
      e.ovf  = model_ovf(v, cfg_digits[sel]);
      e.seg  = model_seg(v, sel);
      sb.push_back(e);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(negedge clk);
          din_valid = 1'b0;
          din = $urandom_range(1, 0) != 0;
        end
      end
      @(negedge clk);
      din         = v[i];
      din_valid   = 1'b1;
      frame_start = fs_first && (i == nbits - 1);
    end
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    check_eq("done_on_last_edge", 64'(done_v[sel]), 64'(exp_done));
    check_eq("busy_after_bits", 64'(busy_v[sel]), 64'(exp_busy));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid   = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_bcd"}, 64'(bcd_all[k]), 64'(0));
      check_eq({tag, "_ovf"}, 64'(ovf_v[k]), 64'(0));
      check_eq({tag, "_busy"}, 64'(busy_v[k]), 64'(0));
      check_eq({tag, "_done"}, 64'(done_v[k]), 64'(0));
      check_eq({tag, "_seg"}, 64'(seg_all[k]), 64'(model_seg(0, k)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // 255 contiguous on 8-bit frames
    sel = 0;
    drive_bits(255, 8, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check_eq("a_digit0_seg5", 64'(seg_a[6:0]), 64'(7'b1101101));

    // 999 fits, 1000 overflows three digits
    sel = 1;
    drive_bits(999, 10, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    drive_bits(1000, 10, 2, 1'b1, 1'b1, 1'b0);
    idle(2);
    check_eq("b_ovf_dash", 64'(seg_b), 64'({3{7'b1000000}}));

    // Leading-zero blanking
    sel = 2;
    drive_bits(7, 8, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    drive_bits(0, 8, 1, 1'b1, 1'b1, 1'b0);
    idle(2);
    check_eq("c_only_digit0", 64'(seg_c), 64'({14'b0, 7'b0111111}));

    // Abort after 4 bits, then a gapped 0x2A frame
    sel = 0;
    drive_bits(4'hF, 4, 0, 1'b1, 1'b0, 1'b1);
    idle(1);
    check_eq("a_busy_partial", 64'(busy_v[0]), 64'(1));
    drive_bits(8'h2A, 8, 3, 1'b1, 1'b1, 1'b0);
    idle(3);
    check_eq("a_bcd_042", 64'(bcd_a), 64'(12'h042));

    // Reset mid-frame, then unframed bits are ignored
    drive_bits(5'h15, 5, 0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    drive_bits(8'hFF, 8, 1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("a_ignored_bcd", 64'(bcd_a), 64'(0));
    drive_bits(100, 8, 2, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Four digits, active-low segments
    sel = 3;
    drive_bits(9999, 14, 2, 1'b1, 1'b1, 1'b0);
    idle(2);
    check_eq("d_bcd_9999", 64'(bcd_d), 64'(16'h9999));
    check_eq("d_seg_not9", 64'(seg_d), 64'({4{~7'b1101111}}));

    idle(4);
    check_eq("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
